// File: rtl/nms_thin_pkg.sv
// Shared definitions for the non-maximum-suppression thinning block:
// frame defaults, field widths, direction codes and FSM states.
package nms_thin_pkg;

    localparam int DEF_IMG_W = 1024;
    localparam int DEF_IMG_H = 768;

    localparam int MAG_W = 12;
    localparam int DIR_W = 2;
    localparam int PIX_W = MAG_W + DIR_W;

    typedef enum logic [DIR_W-1:0] {
        DIR_X   = 2'b00,
        DIR_45  = 2'b01,
        DIR_Y   = 2'b10,
        DIR_135 = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_e;

    // A center survives only if it is not smaller than either neighbor along its gradient.
    function automatic logic [MAG_W-1:0] keep_mag(
        input logic [MAG_W-1:0] center,
        input logic [MAG_W-1:0] nbr_a,
        input logic [MAG_W-1:0] nbr_b
    );
        return ((center >= nbr_a) && (center >= nbr_b)) ? center : '0;
    endfunction

endpackage

// File: rtl/nms_thin_if.sv
// Gradient-in / thinned-pixel-out stream bundle. The master side feeds
// gradients and observes results; the slave side is the thinning block.
interface nms_thin_if;
    import nms_thin_pkg::*;

    logic [PIX_W-1:0] grad_val_dir;
    logic             grad_valid;
    logic             in_ready;
    logic [MAG_W-1:0] nms_val;
    logic [DIR_W-1:0] nms_dir;
    logic             nms_valid;
    logic             frame_done;
    logic             drop_err;

    modport master (
        output grad_val_dir,
        output grad_valid,
        input  in_ready,
        input  nms_val,
        input  nms_dir,
        input  nms_valid,
        input  frame_done,
        input  drop_err
    );

    modport slave (
        input  grad_val_dir,
        input  grad_valid,
        output in_ready,
        output nms_val,
        output nms_dir,
        output nms_valid,
        output frame_done,
        output drop_err
    );

endinterface

// File: rtl/nms_thin_line_delay.sv
// One-line delay built as a circular buffer: dout is the sample written
// DEPTH enabled cycles ago and is consumed in the same cycle it is overwritten.
module nms_thin_line_delay
    import nms_thin_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_W,
    parameter int WIDTH = PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            mem[ptr] <= din;
            ptr      <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/nms_thin.sv
// 3x3 non-maximum suppression over a raster gradient stream; the tail of
// each frame is pushed out by a self-timed zero-data flush.
module nms_thin
    import nms_thin_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic      clk,
    input  logic      rst_n,
    nms_thin_if.slave bus
);

    localparam int NPIX      = IMG_W * IMG_H;
    localparam int PIX_CNT_W = $clog2(NPIX + 1);
    localparam int COL_W     = $clog2(IMG_W + 1);
    localparam int ROW_W     = $clog2(IMG_H + 1);
    localparam int FILL_W    = $clog2(IMG_W + 2);

    state_e state, state_nxt;

    logic [PIX_CNT_W-1:0] in_cnt;
    logic [COL_W-1:0]     flush_cnt;
    logic [FILL_W-1:0]    fill_cnt;
    logic [COL_W-1:0]     col_cnt;
    logic [ROW_W-1:0]     row_cnt;

    logic in_ready, accept, shift, center_shift;
    logic last_in, last_flush, center_ok;
    logic cen_border, cen_last;

    logic [PIX_W-1:0] shift_din, d1, d2;
    logic [MAG_W-1:0] in_mag, d1_mag, d2_mag;
    logic [MAG_W-1:0] top_mag [2];
    logic [MAG_W-1:0] mid_mag [2];
    logic [MAG_W-1:0] bot_mag [2];
    logic [DIR_W-1:0] mid_dir;
    logic [MAG_W-1:0] cen_mag, nbr_a, nbr_b;

    logic [MAG_W-1:0] nms_val_q;
    logic [DIR_W-1:0] nms_dir_q;
    logic             nms_valid_q, frame_done_q, drop_err_q;
    logic             unused_top_dir;

    assign in_ready     = (state != ST_FLUSH);
    assign accept       = bus.grad_valid && in_ready;
    assign shift        = accept || (state == ST_FLUSH);
    assign shift_din    = accept ? bus.grad_val_dir : '0;
    assign last_in      = (in_cnt == PIX_CNT_W'(NPIX - 1));
    assign last_flush   = (flush_cnt == COL_W'(IMG_W));
    assign center_ok    = (fill_cnt == FILL_W'(IMG_W + 1));
    assign center_shift = shift && center_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (accept) state_nxt = last_in ? ST_FLUSH : ST_RUN;
            ST_RUN:   if (accept && last_in) state_nxt = ST_FLUSH;
            ST_FLUSH: if (last_flush) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_cnt    <= '0;
            flush_cnt <= '0;
        end else begin
            if (accept) begin
                in_cnt <= last_in ? '0 : in_cnt + 1'b1;
            end
            if (state == ST_FLUSH) begin
                flush_cnt <= last_flush ? '0 : flush_cnt + 1'b1;
            end
        end
    end

    // fill_cnt counts shifts until the first center reaches the middle tap;
    // row/col then follow the center through the frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_cnt <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
        end else if ((state == ST_FLUSH) && last_flush) begin
            fill_cnt <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
        end else if (shift) begin
            if (!center_ok) begin
                fill_cnt <= fill_cnt + 1'b1;
            end else if (col_cnt == COL_W'(IMG_W - 1)) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == ROW_W'(IMG_H - 1)) ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    assign cen_border = (row_cnt == '0) || (row_cnt == ROW_W'(IMG_H - 1)) ||
                        (col_cnt == '0) || (col_cnt == COL_W'(IMG_W - 1));
    assign cen_last   = (row_cnt == ROW_W'(IMG_H - 1)) && (col_cnt == COL_W'(IMG_W - 1));

    nms_thin_line_delay #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line1 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (shift),
        .din  (shift_din),
        .dout (d1)
    );

    nms_thin_line_delay #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line2 (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (shift),
        .din  (d1),
        .dout (d2)
    );

    assign in_mag         = shift_din[PIX_W-1:DIR_W];
    assign d1_mag         = d1[PIX_W-1:DIR_W];
    assign d2_mag         = d2[PIX_W-1:DIR_W];
    assign unused_top_dir = ^d2[DIR_W-1:0];

    // Each row keeps two registered taps; the third (rightmost) tap is the live
    // input of that row, so the window is judged on the edge that completes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                top_mag[i] <= '0;
                mid_mag[i] <= '0;
                bot_mag[i] <= '0;
            end
            mid_dir <= '0;
        end else if (shift) begin
            top_mag[0] <= d2_mag;
            top_mag[1] <= top_mag[0];
            mid_mag[0] <= d1_mag;
            mid_mag[1] <= mid_mag[0];
            bot_mag[0] <= in_mag;
            bot_mag[1] <= bot_mag[0];
            mid_dir    <= d1[DIR_W-1:0];
        end
    end

    assign cen_mag = mid_mag[0];

    always_comb begin
        nbr_a = mid_mag[1];
        nbr_b = d1_mag;
        case (dir_e'(mid_dir))
            DIR_X: begin
                nbr_a = mid_mag[1];
                nbr_b = d1_mag;
            end
            DIR_45: begin
                nbr_a = d2_mag;
                nbr_b = bot_mag[1];
            end
            DIR_Y: begin
                nbr_a = top_mag[0];
                nbr_b = bot_mag[0];
            end
            DIR_135: begin
                nbr_a = top_mag[1];
                nbr_b = in_mag;
            end
            default: begin
                nbr_a = mid_mag[1];
                nbr_b = d1_mag;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nms_val_q    <= '0;
            nms_dir_q    <= '0;
            nms_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            nms_valid_q  <= center_shift;
            frame_done_q <= center_shift && cen_last;
            if (center_shift) begin
                nms_val_q <= cen_border ? '0 : keep_mag(cen_mag, nbr_a, nbr_b);
                nms_dir_q <= mid_dir;
            end
            if (bus.grad_valid && !in_ready) begin
                drop_err_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.nms_val    = nms_val_q;
    assign bus.nms_dir    = nms_dir_q;
    assign bus.nms_valid  = nms_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.drop_err   = drop_err_q;

endmodule

// File: tb/tb_nms_thin.sv
// Directed bench for nms_thin on an 8x6 frame with hand-worked expected pixels.
`timescale 1ns/1ps
module tb_nms_thin;
    import nms_thin_pkg::*;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nms_thin_if bus();

    nms_thin #(.IMG_W(W), .IMG_H(H)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [PIX_W-1:0] frame [N];

    int out_cnt = 0;
    int done_cnt = 0;
    int done_idx = 0;
    int ready_low_cnt = 0;
    int flush_base = 0;
    logic [MAG_W-1:0] out_val [64];
    logic [DIR_W-1:0] out_dir [64];

    // Monitor: per-reset tallies of emitted pixels, frame_done and flush cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            out_cnt       = 0;
            done_cnt      = 0;
            done_idx      = 0;
            ready_low_cnt = 0;
            flush_base    = 0;
        end else begin
            if (bus.nms_valid) begin
                if (out_cnt < 64) begin
                    out_val[out_cnt] = bus.nms_val;
                    out_dir[out_cnt] = bus.nms_dir;
                end
                out_cnt++;
            end
            if (bus.frame_done) begin
                done_cnt++;
                done_idx = out_cnt;
            end
            if (!bus.in_ready) begin
                if (ready_low_cnt == 0) flush_base = out_cnt;
                ready_low_cnt++;
            end
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [PIX_W-1:0] pix, input logic vld);
        @(posedge clk);
        #1;
        bus.grad_val_dir = pix;
        bus.grad_valid   = vld;
    endtask

    task automatic doReset(input int cycles);
        @(posedge clk);
        #1;
        rst_n            = 1'b0;
        bus.grad_valid   = 1'b0;
        bus.grad_val_dir = '0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input int gap_every, input int n_samples, input int pokes);
        for (int i = 0; i < n_samples; i++) begin
            applyStimulus(frame[i], 1'b1);
            if (gap_every > 0 && (i % gap_every) == gap_every - 1) applyStimulus('0, 1'b0);
        end
        for (int k = 0; k < pokes; k++) applyStimulus({12'd999, 2'b01}, 1'b1);
        applyStimulus('0, 1'b0);
    endtask

    task automatic loadZero();
        for (int i = 0; i < N; i++) frame[i] = '0;
    endtask

    task automatic loadUniform();
        for (int i = 0; i < N; i++) frame[i] = {12'd100, 2'b00};
    endtask

    function automatic int uniformExp(input int idx);
        int r, c;
        r = idx / W;
        c = idx % W;
        return (r == 0 || r == H - 1 || c == 0 || c == W - 1) ? 0 : 100;
    endfunction

    task automatic checkUniform(input string tag);
        checkOutput({tag, "_count"}, out_cnt, N);
        checkOutput({tag, "_done_cnt"}, done_cnt, 1);
        checkOutput({tag, "_done_idx"}, done_idx, N);
        checkOutput({tag, "_ready_low"}, ready_low_cnt, W + 1);
        checkOutput({tag, "_flush_out"}, out_cnt - flush_base, W + 1);
        checkOutput({tag, "_in_ready"}, int'(bus.in_ready), 1);
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("%s_val[%0d]", tag, i), int'(out_val[i]), uniformExp(i));
            checkOutput($sformatf("%s_dir[%0d]", tag, i), int'(out_dir[i]), 0);
        end
    endtask

    initial begin
        bus.grad_valid   = 1'b0;
        bus.grad_val_dir = '0;

        doReset(3);
        checkOutput("rst_nms_valid", int'(bus.nms_valid), 0);
        checkOutput("rst_nms_val", int'(bus.nms_val), 0);
        checkOutput("rst_nms_dir", int'(bus.nms_dir), 0);
        checkOutput("rst_frame_done", int'(bus.frame_done), 0);
        checkOutput("rst_drop_err", int'(bus.drop_err), 0);
        checkOutput("rst_in_ready", int'(bus.in_ready), 1);

        loadUniform();
        sendFrame(0, N, 0);
        waitCycles(20);
        checkUniform("uni");
        checkOutput("uni_drop_err", int'(bus.drop_err), 0);

        doReset(2);
        sendFrame(3, N, 0);
        waitCycles(20);
        checkUniform("gap");

        // Vertical peak kept, then beaten from below.
        doReset(2);
        loadZero();
        frame[19] = {12'd500, 2'b10};
        frame[11] = {12'd400, 2'b00};
        frame[27] = {12'd400, 2'b00};
        sendFrame(0, N, 0);
        waitCycles(20);
        checkOutput("peak_count", out_cnt, N);
        checkOutput("peak_val19", int'(out_val[19]), 500);
        checkOutput("peak_dir19", int'(out_dir[19]), 2);
        checkOutput("peak_val11", int'(out_val[11]), 400);
        checkOutput("peak_val27", int'(out_val[27]), 400);

        doReset(2);
        frame[27] = {12'd600, 2'b00};
        sendFrame(0, N, 0);
        waitCycles(20);
        checkOutput("beat_val19", int'(out_val[19]), 0);
        checkOutput("beat_dir19", int'(out_dir[19]), 2);
        checkOutput("beat_val27", int'(out_val[27]), 600);

        // Diagonal neighbors: 45deg suppressed by top-right, 135deg kept.
        doReset(2);
        loadZero();
        frame[18] = {12'd300, 2'b01};
        frame[11] = {12'd350, 2'b00};
        frame[29] = {12'd200, 2'b11};
        frame[20] = {12'd150, 2'b00};
        frame[38] = {12'd150, 2'b00};
        frame[22] = {12'd250, 2'b00};
        sendFrame(0, N, 0);
        waitCycles(20);
        checkOutput("diag_val18", int'(out_val[18]), 0);
        checkOutput("diag_dir18", int'(out_dir[18]), 1);
        checkOutput("diag_val29", int'(out_val[29]), 200);
        checkOutput("diag_dir29", int'(out_dir[29]), 3);
        checkOutput("diag_val11", int'(out_val[11]), 350);
        checkOutput("diag_val22", int'(out_val[22]), 250);

        // Input offered during flush is dropped and flagged.
        doReset(2);
        loadUniform();
        sendFrame(0, N, 3);
        waitCycles(20);
        checkOutput("drop_count", out_cnt, N);
        checkOutput("drop_done_cnt", done_cnt, 1);
        checkOutput("drop_ready_low", ready_low_cnt, W + 1);
        checkOutput("drop_err_set", int'(bus.drop_err), 1);
        waitCycles(10);
        checkOutput("drop_err_held", int'(bus.drop_err), 1);
        doReset(2);
        checkOutput("drop_err_clr", int'(bus.drop_err), 0);

        // Abandoned frame, then a clean one.
        sendFrame(0, 20, 0);
        doReset(2);
        waitCycles(20);
        checkOutput("abort_count", out_cnt, 0);
        checkOutput("abort_done", done_cnt, 0);
        checkOutput("abort_in_ready", int'(bus.in_ready), 1);
        sendFrame(0, N, 0);
        waitCycles(20);
        checkUniform("rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/nms_thin.md
NMS_THIN -- requirements
Module: nms_thin

Interface
REQ-001 Parameter IMG_W, default 1024: pixels per line.
REQ-002 Parameter IMG_H, default 768: lines per frame.
REQ-003 Port clk, input, 1: single clock; all logic rising-edge.
REQ-004 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port grad_val_dir, input, 14: [13:2] gradient magnitude, [1:0] direction (00 x-axis, 01 45deg, 10 y-axis, 11 135deg).
REQ-006 Port grad_valid, input, 1: grad_val_dir valid this cycle.
REQ-007 Port in_ready, output, 1: block accepts input this cycle.
REQ-008 Port nms_val, output, 12: thinned magnitude, 0 if suppressed.
REQ-009 Port nms_dir, output, 2: direction of emitted pixel.
REQ-010 Port nms_valid, output, 1: nms_val/nms_dir valid this cycle.
REQ-011 Port frame_done, output, 1: one-cycle pulse after last pixel of frame emitted.
REQ-012 Port drop_err, output, 1: sticky flag, input offered while in_ready low.

Function
REQ-013 Accept = grad_valid && in_ready; each accept shifts one sample into 3x3 window (raster order).
REQ-014 Window rows from input, one IMG_W delay line, two IMG_W delay lines; three-tap column shift per row.
REQ-015 Center is sample delayed IMG_W+1 shifts from newest; center pixel (r,c) becomes available on the shift of sample (r+1,c+1) in raster index.
REQ-016 nms_valid asserts exactly one clock after each shift whose center index is >= 0; outputs registered.
REQ-017 Neighbor pair: dir 00 left/right; 01 top-right/bottom-left; 10 top/bottom; 11 top-left/bottom-right.
REQ-018 Keep rule: nms_val = center magnitude if center >= both neighbors (unsigned 12-bit compare), else 0.
REQ-019 Border pixels (r=0, r=IMG_H-1, c=0, c=IMG_W-1) emit nms_val 0 regardless of window contents.
REQ-020 nms_dir = center direction always, including suppressed and border pixels.
REQ-021 Row/col counters track center position; col wraps IMG_W-1 -> 0 with row increment; row wraps at IMG_H-1 end.
REQ-022 FSM IDLE: in_ready 1; first accept -> RUN.
REQ-023 FSM RUN: in_ready 1; accept of sample IMG_W*IMG_H-1 -> FLUSH.
REQ-024 FSM FLUSH: in_ready 0; self-generated shift every cycle with zero data, exactly IMG_W+1 shifts; after last shift -> IDLE.
REQ-025 frame_done pulses one clock with the final nms_valid (center index IMG_W*IMG_H-1).
REQ-026 Exactly IMG_W*IMG_H nms_valid pulses per frame.
REQ-027 grad_valid while in_ready 0: sample ignored, no shift, drop_err set to 1 and held until reset.
REQ-028 Gaps in grad_valid during RUN: no shift, no output, state held.

Reset
REQ-029 rst_n low at clock edge: FSM IDLE, counters 0, window and delay lines 0, nms_val 0, nms_dir 0, nms_valid 0, frame_done 0, drop_err 0, in_ready 1 after release.
REQ-030 Reset mid-frame or mid-flush abandons frame; no further outputs for it.

Structure
REQ-031 Shared package holds IMG_W/IMG_H defaults, direction encodings, FSM state type, magnitude/direction field widths.
REQ-032 One sub-module line_delay: IMG_W-deep, 14-bit, enable-gated delay line, instantiated twice.

Verification (IMG_W=8, IMG_H=6)
REQ-033 Reset: hold rst_n low 3 cycles -> all outputs 0, in_ready 1 after release.
REQ-034 Uniform frame, all magnitude 100 dir 00, continuous valid -> 48 outputs; interior 24 = 100, border 24 = 0; one frame_done.
REQ-035 Peak (2,3)=500 dir 10, (1,3)=(3,3)=400, rest 0 -> (2,3) emits 500; change (3,3) to 600 -> (2,3) emits 0.
REQ-036 After 48th accept -> in_ready low exactly 9 cycles, 9 outputs, frame_done on last, FSM returns IDLE.
REQ-037 grad_valid high during FLUSH -> no extra shift, output count unchanged, drop_err 1 until reset.
REQ-038 Reset after 20 accepts, then full fresh frame -> exactly 48 outputs, values match REQ-034 pattern.
